// File: rtl/run_sequencer_pkg.sv
// run_sequencer_pkg -- constants shared between the run sequencer and the CPU
// control: sequencer state encoding, run outcome codes and the CPU state
// values (idle = 0, exec = 1).
package run_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_EXEC = 3'd2,
        S_RUN       = 3'd3,
        S_DRAIN     = 3'd4,
        S_DONE      = 3'd5
    } run_state_t;

    localparam logic [1:0] STAT_HALTED      = 2'b00;
    localparam logic [1:0] STAT_ABORTED     = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT     = 2'b10;
    localparam logic [1:0] STAT_LAUNCH_FAIL = 2'b11;

    localparam logic CPU_IDLE = 1'b0;
    localparam logic CPU_EXEC = 1'b1;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter -- saturating 32-bit exec-cycle counter.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-low reset
//   i_clear        zero the count (wins over i_inc)
//   i_inc          count one exec cycle (saturates at 32'hFFFFFFFF)
//   i_limit        limit compared against the post-increment value
//   o_count        current count
//   o_reach        the increment taken this cycle reaches (or passes) i_limit
module run_cycle_counter
    import run_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_inc,
    input  logic [31:0] i_limit,
    output logic [31:0] o_count,
    output logic        o_reach
);

    logic [31:0] r_count;
    logic [31:0] w_next;

    assign w_next  = (r_count == CNT_MAX) ? r_count : r_count + 32'd1;
    // Looking at the post-increment value lets the sequencer leave RUN on the
    // same edge the count lands on the limit.
    assign o_reach = (w_next >= i_limit);
    assign o_count = r_count;

    always_ff @(posedge clock) begin
        if (!reset)       r_count <= 32'd0;
        else if (i_clear) r_count <= 32'd0;
        else if (i_inc)   r_count <= w_next;
    end

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer -- launches a CPU run, supervises it and reports the outcome.
// Parameters:
//   TIMEOUT_CYCLES  max counted exec cycles before a forced stop
//   LAUNCH_WAIT     max WAIT_EXEC cycles for the CPU to enter exec
// Ports:
//   clock, reset    rising-edge clock, synchronous active-low reset
//   go              run request (sampled in IDLE only)
//   stop            abort request (honoured in WAIT_EXEC and RUN only)
//   cpu_state       CPU control state, 0 = idle, 1 = exec
//   step            (RUN_SEQ_STEP_EN only) single exec-cycle run request
//   start           one-cycle start strobe to the CPU (LAUNCH)
//   enable          run enable to the CPU (LAUNCH, WAIT_EXEC, RUN)
//   busy            high in every state but IDLE
//   done            one-cycle completion pulse
//   status          00 halted, 01 aborted, 10 timeout, 11 launch_fail
//   cycle_count     exec cycles counted in the last or current run
// Build option: define RUN_SEQ_STEP_EN to add the step input.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter int          LAUNCH_WAIT    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        stop,
    input  logic        cpu_state,
`ifdef RUN_SEQ_STEP_EN
    input  logic        step,
`endif
    output logic        start,
    output logic        enable,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] cycle_count
);

    localparam logic [31:0] LW = 32'(LAUNCH_WAIT);

    run_state_t  r_state, w_state_nxt;
    logic [1:0]  r_status, w_status_nxt;
    logic [31:0] r_wait;
    logic        w_clear, w_inc, w_reach;
    logic        w_start, w_enable, w_busy, w_done;
    logic        w_step_mode;   // current run is a single-step run
    logic [31:0] w_limit;
    logic [1:0]  w_limit_status;

`ifdef RUN_SEQ_STEP_EN
    logic r_step;

    always_ff @(posedge clock) begin
        if (!reset)                       r_step <= 1'b0;
        else if (r_state == S_IDLE && (go || step))
            r_step <= step && !go;        // a plain go takes precedence
    end

    assign w_step_mode = r_step;
`else
    assign w_step_mode = 1'b0;
`endif

    // A step run has a one-cycle budget and ending on it is a normal halt.
    assign w_limit        = w_step_mode ? 32'd1 : TIMEOUT_CYCLES;
    assign w_limit_status = w_step_mode ? STAT_HALTED : STAT_TIMEOUT;

    run_cycle_counter u_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_clear),
        .i_inc   (w_inc),
        .i_limit (w_limit),
        .o_count (cycle_count),
        .o_reach (w_reach)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_clear      = 1'b0;
        w_inc        = 1'b0;
        w_start      = 1'b0;
        w_enable     = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
`ifdef RUN_SEQ_STEP_EN
                if (go || step) begin
`else
                if (go) begin
`endif
                    w_clear      = 1'b1;
                    w_status_nxt = STAT_HALTED;
                    w_state_nxt  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_start     = 1'b1;
                w_enable    = 1'b1;
                w_state_nxt = S_WAIT_EXEC;
            end
            S_WAIT_EXEC: begin
                w_enable = 1'b1;
                // The cycle the CPU is first seen in exec is an exec cycle.
                w_inc    = (cpu_state == CPU_EXEC);
                if (stop) begin
                    w_status_nxt = STAT_ABORTED;
                    w_state_nxt  = S_DRAIN;
                end else if (cpu_state == CPU_EXEC) begin
                    if (w_reach) begin
                        w_status_nxt = w_limit_status;
                        w_state_nxt  = S_DRAIN;
                    end else begin
                        w_state_nxt  = S_RUN;
                    end
                end else if (r_wait + 32'd1 >= LW) begin
                    w_status_nxt = STAT_LAUNCH_FAIL;
                    w_state_nxt  = S_DONE;
                end
            end
            S_RUN: begin
                w_enable = 1'b1;
                // Priority: halt > stop > timeout.
                if (cpu_state == CPU_IDLE) begin
                    w_status_nxt = STAT_HALTED;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_inc = 1'b1;
                    if (stop) begin
                        w_status_nxt = STAT_ABORTED;
                        w_state_nxt  = S_DRAIN;
                    end else if (w_reach) begin
                        w_status_nxt = w_limit_status;
                        w_state_nxt  = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (cpu_state == CPU_IDLE) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_status <= STAT_HALTED;
            r_wait   <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            r_wait   <= (r_state == S_WAIT_EXEC) ? r_wait + 32'd1 : 32'd0;
        end
    end

    // Strobes are gated by reset so the CPU sees enable drop in the very
    // cycle reset is asserted, not one edge later.
    assign start  = reset & w_start;
    assign enable = reset & w_enable;
    assign busy   = reset & w_busy;
    assign done   = reset & w_done;
    assign status = r_status;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

    localparam int TO    = 20;
    localparam int LW    = 8;
    localparam int NEVER = 1000;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0, stop = 1'b0, cpu_state = 1'b0;
    logic        start, enable, busy, done;
    logic [1:0]  status;
    logic [31:0] cycle_count;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    logic prev_done = 1'b0;

    always #5 clock = ~clock;

    run_sequencer #(.TIMEOUT_CYCLES(32'd20), .LAUNCH_WAIT(LW)) dut (
        .clock       (clock),
        .reset       (reset),
        .go          (go),
        .stop        (stop),
        .cpu_state   (cpu_state),
        .start       (start),
        .enable      (enable),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .cycle_count (cycle_count)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Outcome from the run description: the first event (in exec-cycle index)
    // among halt (index n+1), stop (index s) and timeout (index TO) wins,
    // with ties resolved halt > stop > timeout.
    function automatic exp_t model(input int d, input int n, input int s, input int sw);
        int e_halt, e_stop;
        if (sw > 0)                   return '{2'b01, 32'd0};
        if (d < 1 || d > LW || n < 1) return '{2'b11, 32'd0};
        e_halt = n + 1;
        e_stop = (s > 0) ? s : 32'h7fff_ffff;
        if (e_halt <= e_stop && e_halt <= TO) return '{2'b00, 32'(n)};
        if (e_stop <= TO)                     return '{2'b01, 32'(e_stop)};
        return '{2'b10, 32'(TO)};
    endfunction

    // Scoreboard monitor: every done pulse consumes one expected outcome.
    always @(negedge clock) begin
        if (done) begin
            chk("done_width", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL done_unexpected: done pulse with status %0d, none expected", status);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("status", 32'(status), 32'(e.st));
                chk("cycle_count", cycle_count, e.cnt);
            end
        end
        prev_done <= done;
    end

    // One run. d: cycles after start until CPU exec (NEVER = stays idle);
    // n: exec cycles before the CPU halts by itself; s: stop during the s-th
    // exec cycle (0 = none); r: CPU idles r cycles after enable drops;
    // sw: stop at that WAIT_EXEC cycle; gb: stray go at that cycle.
    task automatic run_one(input int d, input int n, input int s, input int r,
                           input int sw, input int gb,
                           output int drain_cyc, output int t_done, output int drop_cnt);
        exp_t e;
        int   t, ex, dr, starts;
        bit   dr_act, seen, fired, c;
        e = model(d, n, s, sw);
        exp_q.push_back(e);
        @(negedge clock); go = 1'b1;
        @(negedge clock); go = 1'b0;
        chk("launch_start", 32'(start), 32'd1);
        chk("launch_enable", 32'(enable), 32'd1);
        t = 0; ex = 0; dr = 0; starts = 0;
        dr_act = 0; seen = 0; fired = 0;
        drain_cyc = 0; t_done = 0; drop_cnt = -1;
        while (!seen && t < 200) begin
            @(negedge clock);
            t++;
            go = (t == gb);
            if (start) starts++;
            if (done) begin
                seen = 1; t_done = t; cpu_state = 1'b0; stop = 1'b0;
            end else begin
                if (busy && !enable && !dr_act) begin
                    dr_act = 1; drop_cnt = int'(cycle_count);
                end
                if (busy && !enable) drain_cyc++;
                if (dr_act) begin
                    c = (dr < r - 1) && (ex < n);
                    dr++;
                end else begin
                    c = (t >= d) && (ex < n);
                end
                if (sw > 0) stop = (t == sw);
                else begin
                    stop = !fired && !dr_act && s > 0 && t >= d && ex == s - 1;
                    if (stop) fired = 1;
                end
                if (c) ex++;
                cpu_state = c;
            end
        end
        go = 1'b0; stop = 1'b0; cpu_state = 1'b0;
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done in 200 cycles, expected status %0d", e.st);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        chk("start_outside_launch", 32'(starts), 32'd0);
        repeat ($urandom_range(1, 3)) @(negedge clock);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("hold_status", 32'(status), 32'(e.st));
        chk("hold_count", cycle_count, e.cnt);
    endtask

    initial begin
        int dc, td, dcnt, t, ex;
        int d, n, s, r, sw, gb;
        bit fired, c;

        repeat (3) @(negedge clock);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_count", cycle_count, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        run_one(2, 15, 0, 1, 0, 0, dc, td, dcnt);              // normal halt
        run_one(2, 100, 10, 3, 0, 0, dc, td, dcnt);            // stop at exec 10
        chk("drain_cycles", 32'(dc), 32'd3);
        run_one(2, NEVER, 0, 2, 0, 6, dc, td, dcnt);           // timeout + stray go
        chk("count_at_drop", 32'(dcnt), 32'(TO));
        run_one(NEVER, 1, 0, 1, 0, 0, dc, td, dcnt);           // launch fail
        chk("launch_fail_latency", 32'(td), 32'(LW + 1));
        run_one(NEVER, 1, 0, 1, 3, 0, dc, td, dcnt);           // stop in WAIT_EXEC
        run_one(2, 5, 6, 2, 0, 0, dc, td, dcnt);               // halt beats stop
        run_one(2, 100, TO, 2, 0, 0, dc, td, dcnt);            // stop ties timeout
        run_one(1, 3, 1, 2, 0, 0, dc, td, dcnt);               // stop on first exec
        run_one(LW, 3, 0, 1, 0, 0, dc, td, dcnt);              // exec at last wait cycle
        run_one(LW + 1, 3, 0, 1, 0, 0, dc, td, dcnt);          // one cycle too late
        run_one(2, TO - 1, 0, 1, 0, 0, dc, td, dcnt);          // halt just before timeout

        // Reset in the 5th exec cycle, go held during reset.
        @(negedge clock); go = 1'b1;
        @(negedge clock); go = 1'b0;
        t = 0; ex = 0; fired = 0;
        while (!fired && t < 50) begin
            @(negedge clock);
            t++;
            c = (t >= 2);
            if (c) ex++;
            cpu_state = c;
            if (ex == 5) begin
                reset = 1'b0; go = 1'b1; fired = 1;
            end
        end
        if (!fired) begin
            vectors++; miscompares++;
            $display("FAIL midrun_reset: exec cycle 5 never reached");
        end
        #1 chk("rst_enable_immediate", 32'(enable), 32'd0);
        @(negedge clock);
        chk("midrst_start", 32'(start), 32'd0);
        chk("midrst_enable", 32'(enable), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_status", 32'(status), 32'd0);
        chk("midrst_count", cycle_count, 32'd0);
        reset = 1'b1; go = 1'b0; cpu_state = 1'b0;
        @(negedge clock);
        chk("post_rst_busy", 32'(busy), 32'd0);

        repeat (40) begin
            d  = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, LW + 2));
            n  = int'($urandom_range(1, 30));
            s  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 32));
            r  = int'($urandom_range(1, 4));
            sw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, LW)) : 0;
            if (sw > 0) d = NEVER;
            gb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            run_one(d, n, s, r, sw, gb, dc, td, dcnt);
        end

        repeat (3) @(negedge clock);
        chk("pending_expects", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd1000000, meaning max counted exec cycles before forced stop.
REQ-002 SHALL have parameter LAUNCH_WAIT, default 8, meaning max cycles from start pulse to CPU entering exec.
REQ-003 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port go  input  1  host run request; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1  host abort request.
REQ-007 SHALL have port cpu_state  input  1  CPU control state: 0 = idle, 1 = exec.
REQ-008 SHALL have port start  output  1  start strobe to CPU control.
REQ-009 SHALL have port enable  output  1  run enable to CPU control.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port status  output  2  run outcome: 00 halted, 01 aborted, 10 timeout, 11 launch_fail.
REQ-013 SHALL have port cycle_count  output  32  exec cycles counted in the last or current run.

Function
REQ-014 SHALL implement states IDLE, LAUNCH, WAIT_EXEC, RUN, DRAIN, DONE.
REQ-015 IDLE: start=0, enable=0; on go=1, SHALL clear cycle_count and status, then go to LAUNCH.
REQ-016 LAUNCH: SHALL hold start=1 and enable=1 for exactly one cycle, then go to WAIT_EXEC.
REQ-017 WAIT_EXEC: enable=1, start=0; on cpu_state=1 go to RUN; after LAUNCH_WAIT cycles without exec, status=11 and go to DONE.
REQ-018 RUN: enable=1; cycle_count SHALL increment by 1 every cycle cpu_state=1, saturating at 32'hFFFFFFFF.
REQ-019 RUN: on cpu_state=0 (CPU halted), status=00 and go to DONE.
REQ-020 RUN: on stop=1, status=01 and go to DRAIN; when cycle_count reaches TIMEOUT_CYCLES, status=10 and go to DRAIN.
REQ-021 Same-cycle priority in RUN SHALL be halt > stop > timeout.
REQ-022 WAIT_EXEC: stop=1 SHALL set status=01 and go to DRAIN (takes priority over launch_fail).
REQ-023 DRAIN: enable=0; SHALL go to DONE once cpu_state=0.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; status and cycle_count SHALL hold until the next accepted go.
REQ-025 go outside IDLE SHALL be ignored; stop outside WAIT_EXEC/RUN SHALL be ignored.
REQ-026 start SHALL never be high in any state other than LAUNCH.

Reset
REQ-027 While reset=0, the block SHALL enter IDLE with start=0, enable=0, busy=0, done=0, status=00, cycle_count=0, including mid-run; enable SHALL drop in the first cycle of reset.

Configuration
REQ-028 With RUN_SEQ_STEP_EN defined, the block SHALL add input step (1 bit); step=1 in IDLE SHALL run the LAUNCH path with a budget of one exec cycle, then go to DRAIN with status=00.
REQ-029 Without RUN_SEQ_STEP_EN, the step port and its logic SHALL be absent; behaviour SHALL be identical otherwise.

Structure
REQ-030 State encodings, status codes, and the idle=0/exec=1 constants SHALL live in the shared header/package used by the CPU control.
REQ-031 The saturating 32-bit counter with clear, increment and compare-to-limit SHALL be a sub-module named run_cycle_counter.

Verification
REQ-032 go pulse, CPU enters exec 2 cycles after start and returns idle after 50 exec cycles -> done pulse, status=00, cycle_count=50.
REQ-033 go, then stop asserted at exec cycle 10, CPU idles 3 cycles later -> enable low for 3 cycles, then done, status=01, cycle_count=10.
REQ-034 TIMEOUT_CYCLES=20, CPU never halts -> enable drops when cycle_count=20, status=10.
REQ-035 LAUNCH_WAIT=8, cpu_state held at 0 -> done after 8 WAIT_EXEC cycles, status=11, cycle_count=0.
REQ-036 reset=0 at exec cycle 5 -> enable=0 on the next edge, all outputs at reset values; a go pulse while busy has no effect.
